// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, the NOP word, instruction field
// positions and the immediate sign-extension helper.
package mips_pkg;

   localparam int unsigned OP_W  = 6;
   localparam int unsigned REG_W = 5;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam int unsigned OP_MSB  = 31;
   localparam int unsigned OP_LSB  = 26;
   localparam int unsigned RS_MSB  = 25;
   localparam int unsigned RS_LSB  = 21;
   localparam int unsigned RT_MSB  = 20;
   localparam int unsigned RT_LSB  = 16;
   localparam int unsigned IMM_MSB = 15;
   localparam int unsigned IMM_LSB = 0;
   localparam int unsigned TGT_MSB = 25;
   localparam int unsigned TGT_LSB = 0;

   function automatic logic [31:0] sext_imm(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection for the instruction held in ID.
// Ports:
//   id_valid, op, rs, rt         - decoded ID instruction
//   ex_reg_write, ex_mem_read,
//   ex_dst                       - EX-stage destination info
//   mem_mem_read, mem_dst        - MEM-stage load info
//   lw_hazard                    - load-use or branch-operand hazard
module hazard_detect
   import mips_pkg::*;
(
   input  logic             id_valid,
   input  logic [OP_W-1:0]  op,
   input  logic [REG_W-1:0] rs,
   input  logic [REG_W-1:0] rt,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_dst,
   input  logic             mem_mem_read,
   input  logic [REG_W-1:0] mem_dst,
   output logic             lw_hazard
);

   logic uses_rt;
   logic is_br;
   logic load_use;
   logic br_hazard;

   always_comb begin
      uses_rt  = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
      is_br    = (op == OP_BEQ) || (op == OP_BNE);

      load_use = id_valid && ex_mem_read && (ex_dst != '0) &&
                 ((ex_dst == rs) || (uses_rt && (ex_dst == rt)));

      // Branches compare in ID, so any in-flight producer of an operand stalls:
      // an ALU result in EX, or a load result still in MEM.
      br_hazard = id_valid && is_br &&
                  ((ex_reg_write && (ex_dst != '0) && ((ex_dst == rs) || (ex_dst == rt))) ||
                   (mem_mem_read && (mem_dst != '0) && ((mem_dst == rs) || (mem_dst == rt))));

      lw_hazard = load_use || br_hazard;
   end

endmodule

// File: rtl/id_fetch_ctrl.sv
// Decode-side fetch control: IF/ID pipeline register, branch/jump resolution
// in ID, hazard stall and wrong-path flush, saturating stall/flush counters.
// Ports:
//   clk, rst_n                   - clock, async active-low reset
//   instruction, output_pc       - fetched word and its PC+1 from IF
//   rs_data, rt_data             - register-file operands for branch compare
//   ex_*/mem_*                   - EX/MEM destination info for hazards
//   mux_ctrl, branch_PC          - redirect select and target to IF
//   lw_hazard                    - IF holds PC
//   id_instr, id_pc, id_valid    - IF/ID register contents
//   id_bubble                    - ID/EX loads a bubble
//   stall_cnt, flush_cnt         - saturating event counters
module id_fetch_ctrl
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP   = NOP_INSTR,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instruction,
   input  logic [31:0]      output_pc,
   input  logic [31:0]      rs_data,
   input  logic [31:0]      rt_data,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_dst,
   input  logic             mem_mem_read,
   input  logic [4:0]       mem_dst,
   output logic             mux_ctrl,
   output logic [31:0]      branch_PC,
   output logic             lw_hazard,
   output logic [31:0]      id_instr,
   output logic [31:0]      id_pc,
   output logic             id_valid,
   output logic             id_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [OP_W-1:0] op;
   logic            stall;
   logic            taken;
   logic [31:0]     br_target;
   logic [31:0]     j_target;

   assign op = id_instr[OP_MSB:OP_LSB];

   hazard_detect u_hazard (
      .id_valid     (id_valid),
      .op           (op),
      .rs           (id_instr[RS_MSB:RS_LSB]),
      .rt           (id_instr[RT_MSB:RT_LSB]),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .ex_dst       (ex_dst),
      .mem_mem_read (mem_mem_read),
      .mem_dst      (mem_dst),
      .lw_hazard    (stall)
   );

   // A stalled branch must not redirect; it is re-evaluated once operands settle.
   always_comb begin
      taken = 1'b0;
      if (id_valid && !stall) begin
         case (op)
            OP_BEQ:  taken = (rs_data == rt_data);
            OP_BNE:  taken = (rs_data != rt_data);
            OP_J:    taken = 1'b1;
            default: taken = 1'b0;
         endcase
      end
   end

   always_comb begin
      br_target = id_pc + sext_imm(id_instr[IMM_MSB:IMM_LSB]);
      j_target  = {id_pc[31:26], id_instr[TGT_MSB:TGT_LSB]};
   end

   // Outputs are gated by rst_n so they read 0 during reset regardless of NOP.
   always_comb begin
      lw_hazard = stall && rst_n;
      id_bubble = stall && rst_n;
      mux_ctrl  = taken && rst_n;
      branch_PC = '0;
      if (rst_n) begin
         branch_PC = (taken && (op == OP_J)) ? j_target : br_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_instr <= NOP;
         id_pc    <= '0;
         id_valid <= 1'b0;
      end else if (stall) begin
         id_instr <= id_instr;
         id_pc    <= id_pc;
         id_valid <= id_valid;
      end else if (taken) begin
         id_instr <= NOP;
         id_pc    <= output_pc;
         id_valid <= 1'b0;
      end else begin
         id_instr <= instruction;
         id_pc    <= output_pc;
         id_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/id_fetch_ctrl.md
# id_fetch_ctrl

Decode-side end of the instruction-fetch interface in the pipelined MIPS core. Holds the IF/ID pipeline register and captures `instruction` and `output_pc` (PC+1, word-addressed) from IF. It resolves beq/bne/j in ID and drives `mux_ctrl`/`branch_PC` back to IF. It detects load-use and branch-operand hazards, drives `lw_hazard` to freeze IF, and flushes the wrong-path instruction.

## Interface
- `NOP`, 32'h0000_0000, instruction word loaded on flush/reset
- `CNT_W`, 16, width of saturating stall/flush counters
- `clk` in 1: single clock; rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instruction` in 32: fetched word from IF.
- `output_pc` in 32: PC+1 of fetched word (word address).
- `rs_data`, `rt_data` in 32 each: register-file read data for ID operands, used for branch compare.
- `ex_reg_write`, `ex_mem_read` in 1 each; `ex_dst` in 5: EX-stage destination info.
- `mem_mem_read` in 1; `mem_dst` in 5: MEM-stage load info.
- `mux_ctrl` out 1: 1 selects `branch_PC` in IF; 0 selects PC+1.
- `branch_PC` out 32: redirect target.
- `lw_hazard` out 1: IF must hold PC this cycle.
- `id_instr`, `id_pc` out 32: IF/ID register contents.
- `id_valid` out 1: `id_instr` is a real, non-squashed instruction.
- `id_bubble` out 1: ID/EX must load a bubble this cycle.
- `stall_cnt`, `flush_cnt` out `CNT_W`: saturating event counters.

## Operation
- **Decode fields:** op = `id_instr[31:26]`, rs = `[25:21]`, rt = `[20:16]`, imm = sign-extended `[15:0]`.
- **Opcodes:** beq 6'h04, bne 6'h05, j 6'h02, lw 6'h23, sw 6'h2B, R-type 6'h00.
- **uses_rt:** true for R-type, beq, bne, sw. **is_br:** beq or bne.
- **Load-use hazard:** `id_valid` & `ex_mem_read` & `ex_dst`≠0 & (`ex_dst`==rs | (uses_rt & `ex_dst`==rt)).
- **Branch-operand hazard:** `id_valid` & is_br & one of:
  - `ex_reg_write` & `ex_dst`≠0 & `ex_dst`∈{rs,rt}
  - `mem_mem_read` & `mem_dst`≠0 & `mem_dst`∈{rs,rt}
- **Stall:** `lw_hazard` = load-use | branch-operand hazard. While it is 1:
  - IF/ID register holds.
  - `id_bubble` = 1.
  - `mux_ctrl` is forced to 0.
- **Taken redirect** (no stall, `id_valid`):
  - beq: `rs_data`==`rt_data`; bne: `rs_data`≠`rt_data`; j: always.
  - Drives `mux_ctrl`=1.
  - `branch_PC` = `id_pc` + imm (32-bit wrap; no shift, word addressing) for beq/bne.
  - `branch_PC` = {`id_pc[31:26]`, `id_instr[25:0]`} for j.
  - When not redirecting, `branch_PC` = `id_pc` + imm, don't-care.
- **Flush:** on a rising edge with taken redirect, the IF/ID register loads `id_instr`=NOP, `id_pc`=`output_pc`, `id_valid`=0.
- **Normal:** the IF/ID register loads `instruction`, `output_pc`, and `id_valid`=1.
- **Priority:** reset > stall > flush > load.
- **Counters:** +1 per stalled cycle / per flush edge. Both saturate at all-ones, with no wrap.

## Timing
- **Reset values:** `id_instr`=NOP, `id_pc`=0, `id_valid`=0, counters 0.
- **Combinational outputs:** `mux_ctrl`, `branch_PC`, `lw_hazard`, and `id_bubble` are combinational from registered state plus EX/MEM/regfile inputs.
- **Output values while reset is asserted:** all four combinational outputs are 0 (registered state is NOP/invalid).
- **Settle time:** combinational outputs must settle within half a cycle, because IF samples them at the falling edge.
- **Load-use stall:** exactly 1 cycle.
- **Branch stalls:**
  - Branch after ALU op: 1 cycle.
  - Branch after lw: 2 cycles (EX match, then MEM match).
- **Redirect penalty:** 1 squashed slot.
- **Reset mid-stall:** stall terminates immediately; no partial counter update.
- **Simultaneous stall and redirect condition:** stall wins and redirect is re-evaluated next cycle.

## Structure
- **Shared package `mips_pkg`:**
  - Opcode constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_LW, OP_SW).
  - NOP constant.
  - Field-slice positions.
- **Sub-module `hazard_detect`:** combinational; computes load-use, branch-operand, and `lw_hazard`.
- **Top-level logic:** the IF/ID register, branch compare/target logic, and counters stay in the top level.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_n`=0 mid-run.
  - Required: `id_instr`=0, `id_valid`=0, `mux_ctrl`=0, `lw_hazard`=0, counters 0 immediately, without waiting for a clock edge.
- **Load-use:**
  - Stimulus: ID holds `add $3,$2,$1`; `ex_mem_read`=1, `ex_dst`=2.
  - Required: `lw_hazard`=1 and `id_bubble`=1 for one cycle; `id_instr` unchanged; `stall_cnt`=1.
- **Taken beq:**
  - Stimulus: `id_pc`=8, imm=3, `rs_data`=`rt_data`=5.
  - Required: `mux_ctrl`=1, `branch_PC`=11; next edge `id_valid`=0, `id_instr`=0, `flush_cnt`=1.
- **Not-taken bne:**
  - Stimulus: `id_pc`=8, equal operands.
  - Required: `mux_ctrl`=0; next edge loads `instruction` with `id_valid`=1.
- **Jump:**
  - Stimulus: `id_pc`=32'h0400_0010, target field 26'h000_0020.
  - Required: `branch_PC`=32'h0400_0020, `mux_ctrl`=1.
- **Branch after lw plus counter saturation:**
  - Stimulus: beq on $4 with lw→$4 in EX, then in MEM.
  - Required: 2 stall cycles, then branch resolves.
  - Stimulus: force 2^16+5 stalls.
  - Required: `stall_cnt`=16'hFFFF.
